// File: rtl/rv_mdu.sv
// rtl/rv_mdu.sv - iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider)
module rv_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]         state;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               neg_a;
   logic               neg_b;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;

   logic               a_signed;
   logic               b_signed;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   special_res;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   fix_res;

   // Operand decode on the accepting edge: magnitudes plus sign flags
   always_comb begin
      a_signed    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      b_signed    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      a_neg       = a_signed && a[WIDTH-1];
      b_neg       = b_signed && b[WIDTH-1];
      a_mag       = a_neg ? -a : a;
      b_mag       = b_neg ? -b : b;
      div_zero    = op[2] && (b == '0);
      div_ovf     = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      special_res = '0;
      if (div_zero) begin
         special_res = op[1] ? a : '1;
      end else begin
         special_res = op[1] ? '0 : a;
      end
   end

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_sh - {1'b0, mag_b};
      if (div_diff[WIDTH]) begin
         div_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      prod  = (neg_a ^ neg_b) ? -acc : acc;
      quo_s = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_s = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (op_q[2]) begin
         fix_res = op_q[1] ? rem_s : quo_s;
      end else if (op_q[1:0] == 2'b00) begin
         fix_res = prod[WIDTH-1:0];
      end else begin
         fix_res = prod[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= '0;
         mag_a  <= '0;
         mag_b  <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         result <= '0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= op;
                  mag_a <= a_mag;
                  mag_b <= b_mag;
                  neg_a <= a_neg;
                  neg_b <= b_neg;
                  cnt   <= '0;
                  acc   <= op[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                  if (div_zero || div_ovf) begin
                     result <= special_res;
                     state  <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= op_q[2] ? div_next : mul_next;
               if (cnt == CW'(WIDTH-1)) begin
                  cnt   <= '0;
                  state <= FIX;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIX: begin
               result <= fix_res;
               state  <= DONE;
            end
            default: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_rv_mdu.sv
// tb/tb_rv_mdu.sv - table-driven self-checking bench for rv_mdu
module tb_rv_mdu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          edges;
   } vec_t;

   vec_t vecs[$];

   rv_mdu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", nm, act, exp);
      end
   endtask

   // Present one operation, measure edges from acceptance to out_valid, check result, handshake.
   task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_res, input int exp_edges);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      op = 3'($urandom);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({nm, "_latency"}, n, exp_edges);
      check({nm, "_result"}, result, exp_res);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op = '0;
      a = '0;
      b = '0;

      vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, W+1});
      vecs.push_back('{3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, W+1});
      vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, W+1});
      vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, W+1});
      vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, W+1});
      vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, W+1});
      vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       W+1});
      vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        W+1});
      vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, W+1});
      vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        W+1});
      vecs.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        W+1});
      vecs.push_back('{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, W+1});
      vecs.push_back('{3'b100, 32'h80000000, 32'd1,        32'h80000000, W+1});
      vecs.push_back('{3'b001, 32'h80000000, 32'hFFFFFFFF, 32'd0,        W+1});
      vecs.push_back('{3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, W+1});
      vecs.push_back('{3'b011, 32'h80000000, 32'd2,        32'd1,        W+1});
      vecs.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
      vecs.push_back('{3'b110, 32'd5,        32'd0,        32'd5,        0});
      vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
      vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
      vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0});
      vecs.push_back('{3'b000, 32'd3,        32'd4,        32'd12,       W+1});

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].edges);
      end

      // Backpressure: hold out_ready low in DONE, result must stay put
      @(negedge clk);
      in_valid = 1'b1;
      op = 3'b000;
      a = 32'd6;
      b = 32'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("bp_latency", n, W+1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("bp_result", result, 32'd54);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      op = 3'b101;
      a = 32'd5;
      b = 32'd0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
      check("bp_no_turnaround", {31'd0, busy}, 32'd0);
      check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

      // Flush mid-CALC together with a new request
      @(negedge clk);
      in_valid = 1'b1;
      op = 3'b101;
      a = 32'd100;
      b = 32'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1;
      op = 3'b101;
      a = 32'd9;
      b = 32'd0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      n = 0;
      for (int k = 0; k < W + 8; k++) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) n++;
      end
      check("flush_stays_idle", n, 0);

      // Asynchronous reset mid-CALC
      @(negedge clk);
      in_valid = 1'b1;
      op = 3'b000;
      a = 32'd11;
      b = 32'd13;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("pre_rst_result", result, 32'd54);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_result", result, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      #1;
      rst = 1'b0;

      run_op("post_rst_mul", 3'b000, 32'd3, 32'd4, 32'd12, W+1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
